// File: rtl/frame_swap_ctrl.sv
// Double-buffer select sequencer: queues swap requests and commits them at tear-free
// frame boundaries, with stall-forced swaps, frame statistics and a swap interrupt.
module frame_swap_ctrl #(
  parameter int STALL_MAX  = 16,
  parameter int CNT_WIDTH  = 32,
  parameter int COAL_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_en,
  input  logic                  i_swap_req,
  input  logic                  i_auto_en,
  input  logic [7:0]            i_frame_div,
  input  logic                  i_frame_done,
  input  logic                  i_wr_busy,
  input  logic                  i_irq_clr,
  output logic                  o_r_buffer,
  output logic                  o_w_buffer,
  output logic                  o_swap_pending,
  output logic                  o_swap_ack,
  output logic                  o_irq,
  output logic                  o_forced,
  output logic [CNT_WIDTH-1:0]  o_frame_count,
  output logic [COAL_WIDTH-1:0] o_coalesced
);

  localparam int STALL_W = $clog2(STALL_MAX + 1);

  typedef enum logic [1:0] {IDLE, PENDING, SWAP} state_t;

  state_t             state, state_nxt;
  logic [7:0]         div_cnt;
  logic [STALL_W-1:0] stall_cnt;
  logic               auto_active, auto_req, eff_req, stall_hit;
  logic               commit, force_swap;
  logic               ack_nxt, coal_inc, stall_inc;

  function automatic logic [COAL_WIDTH-1:0] sat_inc(input logic [COAL_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign auto_active = i_en & i_auto_en & (i_frame_div != 8'd0);
  assign auto_req    = auto_active & i_frame_done & (div_cnt == i_frame_div - 8'd1);
  assign eff_req     = i_en & (i_swap_req | auto_req);
  assign stall_hit   = (stall_cnt == STALL_W'(STALL_MAX - 1));
  assign o_w_buffer  = ~o_r_buffer;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    commit     = 1'b0;
    force_swap = 1'b0;
    if (!i_en) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (eff_req) state_nxt = PENDING;
        PENDING: begin
          // A busy write burst delays the swap until the stall budget runs out.
          if (i_frame_done && (!i_wr_busy || stall_hit)) begin
            state_nxt  = SWAP;
            commit     = 1'b1;
            force_swap = i_wr_busy;
          end
        end
        SWAP:    state_nxt = eff_req ? PENDING : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    ack_nxt   = i_en & (state == SWAP);
    coal_inc  = eff_req & (state == PENDING);
    stall_inc = (state == PENDING) & i_frame_done & i_wr_busy & ~commit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_r_buffer     <= 1'b0;
      o_swap_pending <= 1'b0;
      o_swap_ack     <= 1'b0;
      o_irq          <= 1'b0;
      o_forced       <= 1'b0;
      o_frame_count  <= '0;
      o_coalesced    <= '0;
      div_cnt        <= '0;
      stall_cnt      <= '0;
    end else begin
      o_swap_pending <= (state_nxt == PENDING);
      o_swap_ack     <= ack_nxt;
      if (commit)     o_r_buffer  <= ~o_r_buffer;
      if (force_swap) o_forced    <= 1'b1;
      if (coal_inc)   o_coalesced <= sat_inc(o_coalesced);
      if (ack_nxt)        o_irq <= 1'b1;
      else if (i_irq_clr) o_irq <= 1'b0;
      if (i_en && i_frame_done) o_frame_count <= o_frame_count + 1'b1;
      if (!auto_active)      div_cnt <= '0;
      else if (auto_req)     div_cnt <= '0;
      else if (i_frame_done) div_cnt <= div_cnt + 8'd1;
      if (!i_en || state != PENDING || commit) stall_cnt <= '0;
      else if (stall_inc)                      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
